// File: rtl/dp_timing_gen.sv
// Raster timing generator: merges a valid/ready RGB stream onto the {vsync,hsync,den,R,G,B} bus.
// Build option DP_TIMING_GEN_FALLBACK_BARS_EN: colour bars replace black on underflow pixels.
module dp_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  input  logic        clr_underflow,
  output logic        pix_ready,
  output logic [26:0] DPo,
  output logic        frame_start,
  output logic        underflow
);

  // state | meaning
  // IDLE  | counters held at 0, bus driven low, waiting for en
  // RUN   | raster counters advancing; leaves only at the last pixel of a frame
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

`ifdef DP_TIMING_GEN_FALLBACK_BARS_EN
  localparam logic [11:0] BAR1 = 12'(H_ACTIVE / 4);
  localparam logic [11:0] BAR2 = 12'(H_ACTIVE / 2);
  localparam logic [11:0] BAR3 = 12'(3 * H_ACTIVE / 4);
`endif

  state_t      state;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        run;
  logic        den_c;
  logic        hs_c;
  logic        vs_c;
  logic        xfer;
  logic        h_last;
  logic        v_last;
  logic [23:0] fill;
  logic [23:0] rgb;

  always_comb begin
    run    = (state == RUN);
    den_c  = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_c   = run && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_c   = run && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    h_last = (h_cnt == H_LAST);
    v_last = (v_cnt == V_LAST);
    xfer   = den_c && pix_valid;
`ifdef DP_TIMING_GEN_FALLBACK_BARS_EN
    if (h_cnt < BAR1)      fill = 24'hFF0000;
    else if (h_cnt < BAR2) fill = 24'h00FF00;
    else if (h_cnt < BAR3) fill = 24'h0000FF;
    else                   fill = 24'hFFFFFF;
`else
    fill = 24'h000000;
`endif
    // fill only reaches the bus on an active pixel the source failed to supply
    if (xfer)       rgb = pix_data;
    else if (den_c) rgb = fill;
    else            rgb = 24'h000000;
    pix_ready = den_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      DPo         <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      DPo         <= {vs_c, hs_c, den_c, rgb};
      frame_start <= run && (h_cnt == '0) && (v_cnt == '0);

      if (den_c && !pix_valid) underflow <= 1'b1;
      else if (clr_underflow)  underflow <= 1'b0;

      case (state)
        IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
              v_cnt <= '0;
              if (!en) state <= IDLE;
            end else begin
              v_cnt <= v_cnt + 11'd1;
            end
          end else begin
            h_cnt <= h_cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_timing_gen.sv
// Directed bench for dp_timing_gen using a reduced raster (14 clocks x 7 lines).
module tb_dp_timing_gen;

  localparam int HT = 14;
  localparam int FT = 98;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic        clr_underflow = 1'b0;
  logic        pix_ready;
  logic [26:0] DPo;
  logic        frame_start;
  logic        underflow;

  int checks = 0;
  int failures = 0;

  dp_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .clr_underflow(clr_underflow),
    .pix_ready(pix_ready),
    .DPo(DPo),
    .frame_start(frame_start),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // c counts RUN cycles from the first one (pixel 0,0)
  function automatic logic exp_den(int c);
    int h = c % HT;
    int v = (c / HT) % 7;
    return (h < 8) && (v < 4);
  endfunction

  function automatic logic exp_hs(int c);
    int h = c % HT;
    return (h >= 10) && (h < 12);
  endfunction

  function automatic logic exp_vs(int c);
    int v = (c / HT) % 7;
    return (v == 5);
  endfunction

  function automatic logic [26:0] exp_bus(int c, logic [23:0] d);
    logic de = exp_den(c);
    return {exp_vs(c), exp_hs(c), de, de ? d : 24'h0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; pix_valid = 1'b0; pix_data = 24'h0; clr_underflow = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; pix_valid = 1'b1; pix_data = 24'hAAAAAA;
    step(); step(); step();
    checks++; if (DPo !== 27'h0) begin failures++; $display("FAIL reset_dpo got=%h exp=0", DPo); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_uf got=%b exp=0", underflow); end
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", pix_ready); end
    en = 1'b0; rst_n = 1'b1;
    step(); step(); step();
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", pix_ready); end
    checks++; if (DPo !== 27'h0) begin failures++; $display("FAIL idle_dpo got=%h exp=0", DPo); end
  endtask

  task automatic test_timing();
    logic [23:0] last_rgb;
    logic        xfer;
    int          n_xfer;
    do_reset();
    en = 1'b1; pix_valid = 1'b1; pix_data = 24'd1;
    step();
    last_rgb = 24'h0;
    n_xfer = 0;
    for (int c = 0; c < 2 * FT; c++) begin
      checks++;
      if (pix_ready !== exp_den(c)) begin
        failures++; $display("FAIL timing_ready c=%0d got=%b exp=%b", c, pix_ready, exp_den(c));
      end
      if (c == 0) begin
        checks++;
        if (DPo !== 27'h0 || frame_start !== 1'b0) begin
          failures++; $display("FAIL timing_first c=0 got=%h/%b exp=0/0", DPo, frame_start);
        end
      end else begin
        checks++;
        if (DPo !== exp_bus(c - 1, last_rgb)) begin
          failures++; $display("FAIL timing_dpo c=%0d got=%h exp=%h", c, DPo, exp_bus(c - 1, last_rgb));
        end
        checks++;
        if (frame_start !== ((c - 1) % FT == 0)) begin
          failures++; $display("FAIL timing_fs c=%0d got=%b exp=%b", c, frame_start, ((c - 1) % FT == 0));
        end
      end
      if (pix_ready && pix_valid) n_xfer++;
      if (c % FT == FT - 1) begin
        checks++;
        if (n_xfer != 32) begin failures++; $display("FAIL timing_xfers c=%0d got=%0d exp=32", c, n_xfer); end
        n_xfer = 0;
      end
      xfer = exp_den(c);
      last_rgb = xfer ? pix_data : 24'h0;
      step();
      if (xfer) pix_data = pix_data + 24'd1;
    end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL timing_uf got=%b exp=0", underflow); end
  endtask

  task automatic test_underflow();
    logic        xfer;
    logic [23:0] bar;
`ifdef DP_TIMING_GEN_FALLBACK_BARS_EN
    bar = 24'h00FF00;
`else
    bar = 24'h000000;
`endif
    do_reset();
    en = 1'b1; pix_valid = 1'b1; pix_data = 24'd1;
    step();
    for (int c = 0; c < 12; c++) begin
      if (c == 3) begin
        checks++;
        if (DPo !== {3'b001, bar}) begin failures++; $display("FAIL uf_pixel got=%h exp=%h", DPo, {3'b001, bar}); end
        checks++;
        if (underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", underflow); end
      end
      if (c == 4) begin
        checks++;
        if (DPo !== {3'b001, 24'd3}) begin failures++; $display("FAIL uf_noskip got=%h exp=%h", DPo, {3'b001, 24'd3}); end
      end
      if (c == 10) begin
        checks++;
        if (underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
      end
      if (c == 11) begin
        checks++;
        if (underflow !== 1'b0) begin failures++; $display("FAIL uf_clear got=%b exp=0", underflow); end
      end
      pix_valid = (c != 2);
      clr_underflow = (c == 10);
      xfer = exp_den(c) && pix_valid;
      step();
      if (xfer) pix_data = pix_data + 24'd1;
    end
    clr_underflow = 1'b0;
  endtask

  task automatic test_collision();
    do_reset();
    en = 1'b1; pix_valid = 1'b0;
    step();
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL col_pre got=%b exp=0", underflow); end
    step();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL col_set got=%b exp=1", underflow); end
    clr_underflow = 1'b1;
    step();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL col_setwins got=%b exp=1", underflow); end
    pix_valid = 1'b1;
    step();
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL col_clear got=%b exp=0", underflow); end
    clr_underflow = 1'b0;
  endtask

  task automatic test_stop();
    logic [26:0] eb;
    do_reset();
    en = 1'b1; pix_valid = 1'b1; pix_data = 24'h123456;
    step();
    for (int c = 0; c < FT; c++) begin
      checks++;
      if (pix_ready !== exp_den(c)) begin
        failures++; $display("FAIL stop_ready c=%0d got=%b exp=%b", c, pix_ready, exp_den(c));
      end
      if (c > 0) begin
        eb = exp_bus(c - 1, 24'h0);
        checks++;
        if (DPo[26:24] !== eb[26:24]) begin
          failures++; $display("FAIL stop_sync c=%0d got=%b exp=%b", c, DPo[26:24], eb[26:24]);
        end
      end
      en = (c < 20) || (c >= 40 && c < 45);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (pix_ready !== 1'b0 || DPo !== 27'h0 || frame_start !== 1'b0) begin
        failures++; $display("FAIL stop_idle i=%0d got=%b/%h/%b exp=0/0/0", i, pix_ready, DPo, frame_start);
      end
      step();
    end
    en = 1'b1;
    step();
    checks++;
    if (pix_ready !== 1'b1 || frame_start !== 1'b0) begin
      failures++; $display("FAIL restart_first got=%b/%b exp=1/0", pix_ready, frame_start);
    end
    step();
    checks++;
    if (frame_start !== 1'b1 || DPo !== {3'b001, 24'h123456}) begin
      failures++; $display("FAIL restart_fs got=%b/%h exp=1/%h", frame_start, DPo, {3'b001, 24'h123456});
    end
  endtask

  task automatic test_reset_midframe();
    logic        xfer;
    logic [23:0] d0;
    do_reset();
    en = 1'b1; pix_valid = 1'b1; pix_data = 24'd1;
    step();
    for (int c = 0; c < 2 * HT + 5; c++) begin
      pix_valid = (c != 30);
      xfer = exp_den(c) && pix_valid;
      step();
      if (xfer) pix_data = pix_data + 24'd1;
    end
    checks++;
    if (underflow !== 1'b1 || DPo[24] !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre got=%b/%b exp=1/1", underflow, DPo[24]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (DPo !== 27'h0) begin failures++; $display("FAIL rstmid_dpo got=%h exp=0", DPo); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL rstmid_uf got=%b exp=0", underflow); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rstmid_fs got=%b exp=0", frame_start); end
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", pix_ready); end
    step(); step();
    rst_n = 1'b1; pix_valid = 1'b1; pix_data = 24'hC0FFEE;
    d0 = pix_data;
    step();
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL rstmid_run got=%b exp=1", pix_ready); end
    step();
    checks++;
    if (frame_start !== 1'b1 || DPo !== {3'b001, d0}) begin
      failures++; $display("FAIL rstmid_clean got=%b/%h exp=1/%h", frame_start, DPo, {3'b001, d0});
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_underflow();
    test_collision();
    test_stop();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
